dsp_16x8: RTL and testbench

Signed-by-unsigned multiply-accumulate slice: multiplies a signed 16-bit coefficient by an unsigned 8-bit pixel and adds a 48-bit cascade input, producing a 48-bit registered result. It is the basic tap of the filter/convolution datapath. Slices are chained by feeding one slice's `p_o` into the next slice's `pc_i`. It maps onto one DSP48-style primitive with a fixed 2-cycle pipeline.

---
 rtl/dsp_pkg.sv | 13 +
 rtl/dsp_16x8.sv | 58 +++++
 tb/tb_dsp_16x8.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared widths and operand types for the multiply-accumulate slices.
package dsp_pkg;

    localparam int DSP_A_W = 16;
    localparam int DSP_B_W = 8;
    localparam int DSP_P_W = 48;
    localparam int DSP_M_W = DSP_A_W + DSP_B_W;

    typedef logic signed [DSP_A_W-1:0] coef_t;
    typedef logic        [DSP_B_W-1:0] pix_t;
    typedef logic signed [DSP_P_W-1:0] acc_t;

endpackage

// File: rtl/dsp_16x8.sv
// Signed coefficient x unsigned pixel MAC tap with cascade add; 2-cycle pipeline
// (M and P registers), chained via p_o -> pc_i of the next slice.
module dsp_16x8
    import dsp_pkg::*;
#(
    parameter int A_W = DSP_A_W,
    parameter int B_W = DSP_B_W,
    parameter int P_W = DSP_P_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    input  logic [P_W-1:0] pc_i,
    output logic [P_W-1:0] p_o
);

    localparam int M_W = A_W + B_W;

    logic [M_W-1:0] w_a_ext;
    logic [M_W-1:0] w_b_ext;
    logic [M_W-1:0] w_prod;
    logic [P_W-1:0] w_m_ext;
    logic [P_W-1:0] w_sum;

    logic [M_W-1:0] r_m;
    logic [P_W-1:0] r_pc;
    logic [P_W-1:0] r_p;

    // Pixel is zero-extended, so the M_W-bit product is exact and never overflows.
    assign w_a_ext = {{B_W{a[A_W-1]}}, a};
    assign w_b_ext = {{A_W{1'b0}}, b};
    assign w_prod  = $signed(w_a_ext) * $signed(w_b_ext);

    assign w_m_ext = {{(P_W-M_W){r_m[M_W-1]}}, r_m};
    assign w_sum   = w_m_ext + r_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m  <= '0;
            r_pc <= '0;
        end else begin
            r_m  <= w_prod;
            r_pc <= pc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else begin
            r_p <= w_sum;
        end
    end

    assign p_o = r_p;

endmodule

// File: tb/tb_dsp_16x8.sv
// Directed bench for dsp_16x8: reset, latency, signedness, extremes, pipelining, wrap.
module tb_dsp_16x8;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [7:0]  b;
    logic [47:0] pc_i;
    logic [47:0] p_o;

    int checks;
    int errors;

    dsp_16x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .pc_i  (pc_i),
        .p_o   (p_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [47:0] exp);
        logic signed [47:0] obs;
        obs = p_o;
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] ta, input logic [7:0] tb_, input logic [47:0] tpc);
        a    = ta;
        b    = tb_;
        pc_i = tpc;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        rst_n = 1'b0;
        drive(16'd5, 8'd5, 48'd7);
        #2;
        check("reset_t0", 48'sd0);
        tick();
        check("reset_e1", 48'sd0);
        tick();
        check("reset_e2", 48'sd0);
        tick();
        check("reset_e3", 48'sd0);

        drive(16'd10, 8'd5, 48'd0);
        rst_n = 1'b1;
        tick();
        check("pos_1edge", 48'sd0);
        tick();
        check("pos_2edge", 48'sd50);

        drive(-16'sd10, 8'd5, 48'd100);
        tick();
        tick();
        check("signed_coef", 48'sd50);

        drive(-16'sd32768, 8'd255, 48'd0);
        tick();
        tick();
        check("extreme_neg", -48'sd8355840);

        drive(16'sd32767, 8'd255, 48'd0);
        tick();
        tick();
        check("extreme_pos", 48'sd8355585);

        drive(16'd2, 8'd50, 48'd5000);
        tick();
        tick();
        check("accumulate", 48'sd5100);

        drive(16'd3, 8'd7, 48'd1);
        tick();
        drive(-16'sd1, 8'd255, 48'd0);
        tick();
        check("b2b_0", 48'sd22);
        drive(-16'sd7, 8'd128, 48'd1000);
        tick();
        check("b2b_1", -48'sd255);
        drive(16'd0, 8'd0, 48'd0);
        tick();
        check("b2b_2", 48'sd104);

        drive(16'd1, 8'd1, 48'sh7FFF_FFFF_FFFF);
        tick();
        tick();
        check("wrap_pos", 48'sh8000_0000_0000);

        drive(-16'sd1, 8'd1, 48'sh8000_0000_0000);
        tick();
        tick();
        check("wrap_neg", 48'sh7FFF_FFFF_FFFF);

        drive(16'd2, 8'd50, 48'd5000);
        tick();
        tick();
        check("pre_midreset", 48'sd5100);
        drive(16'd3, 8'd3, 48'd0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_async", 48'sd0);
        drive(16'd0, 8'd0, 48'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("post_release_1", 48'sd0);
        tick();
        check("post_release_2", 48'sd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
